// File: rtl/nios2_oci_dct_capture_if.sv
// Trace-beat input stream and FWFT word read port of nios2_oci_dct_capture.
// The capture block takes the slave side; the trace source/readout takes the master side.
interface nios2_oci_dct_capture_if #(
   parameter int FRAME_W     = 2,
   parameter int NUM_FRAMES  = 15,
   parameter int CNT_W       = 4,
   parameter int WORD_FRAMES = 16
);
   localparam int OUT_W = FRAME_W * WORD_FRAMES;

   logic [FRAME_W*NUM_FRAMES-1:0] dct_buffer;
   logic [CNT_W-1:0]              dct_count;
   logic                          dct_valid;
   logic [OUT_W-1:0]              out_data;
   logic                          out_last;
   logic                          out_valid;
   logic                          out_ready;

   modport master (
      output dct_buffer, dct_count, dct_valid, out_ready,
      input  out_data, out_last, out_valid
   );

   modport slave (
      input  dct_buffer, dct_count, dct_valid, out_ready,
      output out_data, out_last, out_valid
   );
endinterface

// File: rtl/nios2_oci_dct_capture.sv
// Packs Nios II OCI DCT trace beats into dense OUT_W-bit words and queues them in a FWFT FIFO.
// Optional accepted-frame counter: define OCI_DCT_FRAME_COUNT_EN to build frames_total.
module nios2_oci_dct_capture #(
   parameter  int FRAME_W     = 2,
   parameter  int NUM_FRAMES  = 15,
   parameter  int CNT_W       = 4,
   parameter  int WORD_FRAMES = 16,
   parameter  int DEPTH       = 16,
   localparam int ADDR_W      = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   nios2_oci_dct_capture_if.slave bus,
   input  logic                   test_ending,
   input  logic                   test_has_ended,
   output logic [ADDR_W:0]        fill_level,
   output logic                   overflow,
   output logic                   ended,
   output logic [31:0]            frames_total
);
   localparam int OUT_W      = FRAME_W * WORD_FRAMES;
   localparam int IN_W       = FRAME_W * NUM_FRAMES;
   localparam int ACC_FRAMES = WORD_FRAMES + NUM_FRAMES - 1;
   localparam int ACC_W      = FRAME_W * ACC_FRAMES;
   localparam int PW         = $clog2(ACC_FRAMES + 1);

   typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

   state_t            state;
   logic [ACC_W-1:0]  acc;
   logic [PW-1:0]     pend;
   logic [PW-1:0]     beat_n;
   logic [PW-1:0]     sum;
   logic [IN_W-1:0]   masked;
   logic [ACC_W-1:0]  merged;
   logic              accept;
   logic              word_done;
   logic              flush_wr;
   logic              full;
   logic              rd_en;
   logic              wr_en;
   logic [OUT_W-1:0]  wr_data;
   logic              wr_last;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [OUT_W:0]    mem [DEPTH];
   logic [OUT_W:0]    head;

   always_comb begin
      if (32'(bus.dct_count) > 32'(NUM_FRAMES))
         beat_n = PW'(NUM_FRAMES);
      else
         beat_n = PW'(bus.dct_count);
   end

   // Frames above the valid count are zeroed so the accumulator stays clean above p,
   // which is what makes the flush word's zero padding come for free.
   always_comb begin
      masked = '0;
      for (int i = 0; i < NUM_FRAMES; i++) begin
         if (i < int'(beat_n))
            masked[i*FRAME_W +: FRAME_W] = bus.dct_buffer[i*FRAME_W +: FRAME_W];
      end
   end

   assign merged    = acc | (ACC_W'(masked) << (FRAME_W * int'(pend)));
   assign sum       = pend + beat_n;
   assign accept    = (state == RUN) && bus.dct_valid && !test_has_ended && (beat_n != '0);
   assign word_done = accept && (sum >= PW'(WORD_FRAMES));

   assign full     = (fill_level == (ADDR_W+1)'(DEPTH));
   assign rd_en    = bus.out_valid && bus.out_ready;
   assign flush_wr = (state == FLUSH) && !test_has_ended && (!full || rd_en);
   assign wr_en    = flush_wr || (word_done && (!full || rd_en));
   assign wr_data  = flush_wr ? acc[OUT_W-1:0] : merged[OUT_W-1:0];
   assign wr_last  = flush_wr;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= {wr_last, wr_data};
   end

   // Head is gated by out_valid so an empty FIFO presents all-zero data and last.
   assign head          = mem[rd_ptr];
   assign bus.out_valid = (fill_level != '0);
   assign bus.out_data  = bus.out_valid ? head[OUT_W-1:0] : '0;
   assign bus.out_last  = bus.out_valid & head[OUT_W];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + ADDR_W'(1);
         if (rd_en)
            rd_ptr <= rd_ptr + ADDR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   fill_level <= fill_level + (ADDR_W+1)'(1);
            2'b01:   fill_level <= fill_level - (ADDR_W+1)'(1);
            default: fill_level <= fill_level;
         endcase
      end
   end

   // Control FSM; a hard stop overrides flush and beat acceptance in every state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         acc      <= '0;
         pend     <= '0;
         overflow <= 1'b0;
         ended    <= 1'b0;
      end else begin
         if (word_done && !wr_en)
            overflow <= 1'b1;
         case (state)
            RUN: begin
               if (test_has_ended) begin
                  state <= DONE;
                  ended <= 1'b1;
                  acc   <= '0;
                  pend  <= '0;
               end else begin
                  if (accept) begin
                     if (word_done) begin
                        acc  <= merged >> OUT_W;
                        pend <= sum - PW'(WORD_FRAMES);
                     end else begin
                        acc  <= merged;
                        pend <= sum;
                     end
                  end
                  if (test_ending)
                     state <= FLUSH;
               end
            end
            FLUSH: begin
               if (test_has_ended || flush_wr) begin
                  state <= DONE;
                  ended <= 1'b1;
                  acc   <= '0;
                  pend  <= '0;
               end
            end
            DONE: begin
               ended <= 1'b1;
            end
            default: begin
               state <= DONE;
               ended <= 1'b1;
            end
         endcase
      end
   end

`ifdef OCI_DCT_FRAME_COUNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         frames_total <= '0;
      else if (accept)
         frames_total <= frames_total + 32'(beat_n);
   end
`else
   assign frames_total = 32'd0;
`endif

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// Scoreboard bench for nios2_oci_dct_capture: a frame-queue model predicts words, a monitor
// pops and compares on every read handshake.
module tb_nios2_oci_dct_capture;
   localparam int FRAME_W     = 2;
   localparam int NUM_FRAMES  = 15;
   localparam int CNT_W       = 4;
   localparam int WORD_FRAMES = 16;
   localparam int DEPTH       = 16;
   localparam int ADDR_W      = 4;
   localparam int OUT_W       = FRAME_W * WORD_FRAMES;
   localparam int IN_W        = FRAME_W * NUM_FRAMES;

   logic              clk = 1'b0;
   logic              reset;
   logic              test_ending;
   logic              test_has_ended;
   logic [ADDR_W:0]   fill_level;
   logic              overflow;
   logic              ended;
   logic [31:0]       frames_total;

   nios2_oci_dct_capture_if #(
      .FRAME_W(FRAME_W), .NUM_FRAMES(NUM_FRAMES), .CNT_W(CNT_W), .WORD_FRAMES(WORD_FRAMES)
   ) bus ();

   nios2_oci_dct_capture #(
      .FRAME_W(FRAME_W), .NUM_FRAMES(NUM_FRAMES), .CNT_W(CNT_W),
      .WORD_FRAMES(WORD_FRAMES), .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .test_ending(test_ending),
      .test_has_ended(test_has_ended),
      .fill_level(fill_level),
      .overflow(overflow),
      .ended(ended),
      .frames_total(frames_total)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OUT_W-1:0] data;
      logic             last;
   } word_t;

   word_t       expQ[$];
   int          pending[$];
   int          mFill;
   bit          mOverflow;
   bit          mEnded;
   bit          mFlushing;
   logic [31:0] mFrames;
   int          nTests = 0;
   int          nFail  = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [OUT_W-1:0] takeWord(input int cnt);
      logic [OUT_W-1:0] w;
      w = '0;
      for (int i = 0; i < cnt; i++)
         w |= OUT_W'(pending.pop_front()) << (FRAME_W * i);
      return w;
   endfunction

   task automatic modelClear();
      expQ.delete();
      pending.delete();
      mFill     = 0;
      mOverflow = 0;
      mEnded    = 0;
      mFlushing = 0;
      mFrames   = 0;
   endtask

   // One clock edge of the reference: frames go into a queue, every 16 form a word.
   task automatic modelStep(input bit v, input int cnt, input logic [IN_W-1:0] frames,
                            input bit ending, input bit hard, input bit rdy);
      bit               rd;
      bit               room;
      int               wrote;
      int               n;
      logic [OUT_W-1:0] w;
      rd    = rdy && (mFill > 0);
      room  = (mFill < DEPTH) || rd;
      wrote = 0;
      if (mEnded) begin
         wrote = 0;
      end else if (hard) begin
         mEnded = 1;
         pending.delete();
      end else if (mFlushing) begin
         if (room) begin
            w = takeWord(pending.size());
            expQ.push_back('{data: w, last: 1'b1});
            wrote  = 1;
            mEnded = 1;
         end
      end else begin
         n = (cnt > NUM_FRAMES) ? NUM_FRAMES : cnt;
         if (v) begin
            for (int i = 0; i < n; i++)
               pending.push_back(int'(frames[i*FRAME_W +: FRAME_W]));
            mFrames += 32'(n);
         end
         if (pending.size() >= WORD_FRAMES) begin
            w = takeWord(WORD_FRAMES);
            if (room) begin
               expQ.push_back('{data: w, last: 1'b0});
               wrote = 1;
            end else begin
               mOverflow = 1;
            end
         end
         if (ending)
            mFlushing = 1;
      end
      mFill = mFill + wrote - (rd ? 1 : 0);
   endtask

   task automatic checkState();
      checkOutput("fill_level", 64'(fill_level), 64'(mFill));
      checkOutput("out_valid", 64'(bus.out_valid), 64'(mFill > 0));
      checkOutput("overflow", 64'(overflow), 64'(mOverflow));
      checkOutput("ended", 64'(ended), 64'(mEnded));
`ifdef OCI_DCT_FRAME_COUNT_EN
      checkOutput("frames_total", 64'(frames_total), 64'(mFrames));
`else
      checkOutput("frames_total", 64'(frames_total), 64'd0);
`endif
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      checkOutput({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
      checkOutput({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
      checkOutput({tag, "_fill_level"}, 64'(fill_level), 64'd0);
      checkOutput({tag, "_overflow"}, 64'(overflow), 64'd0);
      checkOutput({tag, "_ended"}, 64'(ended), 64'd0);
      checkOutput({tag, "_frames_total"}, 64'(frames_total), 64'd0);
   endtask

   // Drives one cycle of inputs, lets the edge happen, then advances and checks the model.
   task automatic applyStimulus(input bit v, input int cnt, input logic [IN_W-1:0] frames,
                                input bit ending, input bit hard, input bit rdy);
      bus.dct_valid  = v;
      bus.dct_count  = CNT_W'(cnt);
      bus.dct_buffer = frames;
      test_ending    = ending;
      test_has_ended = hard;
      bus.out_ready  = rdy;
      @(posedge clk);
      #1;
      modelStep(v, cnt, frames, ending, hard, rdy);
      checkState();
   endtask

   task automatic idle(input bit rdy);
      applyStimulus(1'b0, 0, '0, 1'b0, 1'b0, rdy);
   endtask

   task automatic doReset();
      reset          = 1'b1;
      bus.dct_valid  = 1'b0;
      bus.dct_count  = '0;
      bus.dct_buffer = '0;
      bus.out_ready  = 1'b0;
      test_ending    = 1'b0;
      test_has_ended = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      modelClear();
      #1;
      checkResetValues("reset");
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (mFill > 0 && guard < 64) begin
         idle(1'b1);
         guard++;
      end
      checkOutput("drain_done", 64'(mFill), 64'd0);
      checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
   endtask

   always @(negedge clk) begin : monitor
      word_t e;
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (expQ.size() == 0) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL unexpected_word: got 0x%0h expected no word", bus.out_data);
         end else begin
            e = expQ.pop_front();
            checkOutput("out_data", 64'(bus.out_data), 64'(e.data));
            checkOutput("out_last", 64'(bus.out_last), 64'(e.last));
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      logic [IN_W-1:0] frames;
      logic [31:0]     r;
      int              len;
      int              readyPct;

      reset = 1'b1;
      bus.dct_valid = 1'b0;
      bus.dct_count = '0;
      bus.dct_buffer = '0;
      bus.out_ready = 1'b0;
      test_ending = 1'b0;
      test_has_ended = 1'b0;
      modelClear();
      #12;
      checkResetValues("por");

      // Packing: 15 frames then 1 frame of value i&3 -> 0xE4E4E4E4.
      doReset();
      for (int i = 0; i < NUM_FRAMES; i++)
         frames[i*FRAME_W +: FRAME_W] = FRAME_W'(i & 3);
      applyStimulus(1'b1, 15, frames, 1'b0, 1'b0, 1'b0);
      r = $urandom();
      frames = {r[IN_W-1:2], 2'b11};
      applyStimulus(1'b1, 1, frames, 1'b0, 1'b0, 1'b0);
      checkOutput("pack_word", 64'(bus.out_data), 64'h00000000E4E4E4E4);
      checkOutput("pack_last", 64'(bus.out_last), 64'd0);
      checkOutput("pack_fill", 64'(fill_level), 64'd1);
      drain();

      // Carry-over: three full beats yield two words with 13 frames left over.
      doReset();
      for (int k = 0; k < 3; k++) begin
         r = $urandom();
         applyStimulus(1'b1, 15, r[IN_W-1:0], 1'b0, 1'b0, 1'b0);
      end
      checkOutput("carry_fill", 64'(fill_level), 64'd2);
      checkOutput("carry_last", 64'(bus.out_last), 64'd0);
      checkOutput("carry_pending", 64'(pending.size()), 64'd13);
      drain();

      // Flush: five frames of 3 then test_ending -> 0x3FF with last.
      doReset();
      r = $urandom();
      applyStimulus(1'b1, 5, {r[IN_W-1:10], 10'h3FF}, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, '0, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      checkOutput("flush_word", 64'(bus.out_data), 64'h3FF);
      checkOutput("flush_last", 64'(bus.out_last), 64'd1);
      checkOutput("flush_ended", 64'(ended), 64'd1);
      for (int k = 0; k < 3; k++) begin
         r = $urandom();
         applyStimulus(1'b1, 15, r[IN_W-1:0], 1'b0, 1'b0, 1'b0);
      end
      checkOutput("done_ignores_fill", 64'(fill_level), 64'd1);
      drain();

      // Hard stop with test_ending in the same cycle discards pending frames.
      doReset();
      r = $urandom();
      applyStimulus(1'b1, 7, r[IN_W-1:0], 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, '0, 1'b1, 1'b1, 1'b0);
      idle(1'b0);
      idle(1'b0);
      checkOutput("hard_fill", 64'(fill_level), 64'd0);
      checkOutput("hard_ended", 64'(ended), 64'd1);

      // Overflow: 19 beats of 15 produce 17 words into a 16-deep FIFO, then a stalled flush.
      doReset();
      for (int k = 0; k < 19; k++) begin
         r = $urandom();
         applyStimulus(1'b1, 15, r[IN_W-1:0], 1'b0, 1'b0, 1'b0);
      end
      checkOutput("ovf_fill", 64'(fill_level), 64'd16);
      checkOutput("ovf_flag", 64'(overflow), 64'd1);
      applyStimulus(1'b0, 0, '0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++)
         idle(1'b0);
      checkOutput("stall_not_ended", 64'(ended), 64'd0);
      idle(1'b1);
      checkOutput("stall_released", 64'(ended), 64'd1);
      drain();

      // Counter and asynchronous mid-stream reset.
      doReset();
      for (int k = 0; k < 4; k++) begin
         r = $urandom();
         applyStimulus(1'b1, 15, r[IN_W-1:0], 1'b0, 1'b0, 1'b0);
      end
`ifdef OCI_DCT_FRAME_COUNT_EN
      checkOutput("frames_60", 64'(frames_total), 64'd60);
`endif
      checkOutput("pre_reset_fill", 64'(fill_level), 64'd3);
      #2;
      reset = 1'b1;
      #1;
      checkResetValues("mid");
      @(posedge clk);
      #1;
      reset = 1'b0;
      modelClear();

      // Randomised rounds ending in either a flush or a hard stop.
      for (int round = 0; round < 8; round++) begin
         doReset();
         len = 60 + int'($urandom_range(0, 140));
         readyPct = (round % 3 == 0) ? 15 : 70;
         for (int c = 0; c < len; c++) begin
            r = $urandom();
            applyStimulus(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), r[IN_W-1:0],
                          1'b0, 1'b0, (int'($urandom_range(0, 99)) < readyPct));
         end
         if (round % 4 == 3)
            applyStimulus(1'b1, 9, '1, 1'b1, 1'b1, 1'b0);
         else
            applyStimulus(1'b1, int'($urandom_range(0, 15)), r[IN_W-1:0], 1'b1, 1'b0, 1'b0);
         for (int c = 0; c < 4; c++)
            idle(1'b0);
         drain();
         checkOutput("round_ended", 64'(ended), 64'd1);
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
